// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; one quotient bit per cycle, result laid out as {remainder, quotient}.
// Optional: define DIV_ZERO_FAST_EN to finish a divide-by-zero one cycle after acceptance.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic                  cancel,
    output logic                  stall,
    output logic                  result_valid,
    output logic [2*DATA_W-1:0]   result
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  dvd;      // dividend magnitude, shifted out MSB first
    logic [DATA_W-1:0]  dvs;      // divisor magnitude
    logic [DATA_W-1:0]  quot;
    logic [DATA_W:0]    rem;
    logic [CNT_W-1:0]   count;
    logic               q_neg;
    logic               r_neg;
    logic               sgn;

    logic               b_zero;
    logic [DATA_W-1:0]  a_mag;
    logic [DATA_W-1:0]  b_mag;
    logic [DATA_W:0]    rem_shift;
    logic [DATA_W+1:0]  diff;
    logic               no_borrow;
    logic               fix_en;
    logic [DATA_W-1:0]  quot_fix;
    logic [DATA_W-1:0]  rem_fix;

    // A zero divisor keeps the raw dividend so the iteration leaves it untouched in the remainder.
    assign b_zero = (b == '0);
    assign a_mag  = (is_signed && a[DATA_W-1] && !b_zero) ? -a : a;
    assign b_mag  = (is_signed && b[DATA_W-1]) ? -b : b;

    assign rem_shift = {rem[DATA_W-1:0], dvd[DATA_W-1]};
    assign diff      = {1'b0, rem_shift} - {2'b00, dvs};
    assign no_borrow = ~diff[DATA_W+1];

    assign fix_en   = sgn && (dvs != '0);
    assign quot_fix = (fix_en && q_neg) ? -quot : quot;
    assign rem_fix  = (fix_en && r_neg) ? -rem[DATA_W-1:0] : rem[DATA_W-1:0];

    assign stall = (state == BUSY) || ((state == IDLE) && start && !cancel);

    // NOTE: every register here is updated with non-blocking assignments so all of them
    // see the pre-edge values of each other; blocking would chain the updates within one edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            dvd          <= '0;
            dvs          <= '0;
            quot         <= '0;
            rem          <= '0;
            count        <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            sgn          <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else if (cancel) begin
            state        <= IDLE;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_valid <= 1'b0;
                    if (start) begin
                        dvd   <= a_mag;
                        dvs   <= b_mag;
                        quot  <= '0;
                        rem   <= '0;
                        count <= '0;
                        q_neg <= a[DATA_W-1] ^ b[DATA_W-1];
                        r_neg <= a[DATA_W-1];
                        sgn   <= is_signed;
                        state <= BUSY;
`ifdef DIV_ZERO_FAST_EN
                        // Preload the finished divide-by-zero answer; BUSY then retires it next edge.
                        if (b_zero) begin
                            rem   <= {1'b0, a};
                            quot  <= '1;
                            count <= CNT_W'(DATA_W);
                        end
`endif
                    end
                end
                BUSY: begin
                    if (count == CNT_W'(DATA_W)) begin
                        result       <= {rem_fix, quot_fix};
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end else begin
                        rem   <= no_borrow ? diff[DATA_W:0] : rem_shift;
                        quot  <= {quot[DATA_W-2:0], no_borrow};
                        dvd   <= dvd << 1;
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    // start is still the same instruction here, so it is not looked at.
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    result_valid <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases, randomized operands against an arithmetic model,
// cancel, asynchronous reset mid-divide and back-to-back issue.
module tb_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          is_signed;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cancel;
    logic          stall;
    logic          result_valid;
    logic [2*W-1:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .is_signed    (is_signed),
        .a            (a),
        .b            (b),
        .cancel       (cancel),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result)
    );

    // Reference: plain integer division (truncating), remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y, input logic s);
        longint sx, sy, q, r;
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (s) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
        end else begin
            sx = longint'({32'd0, x});
            sy = longint'({32'd0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
        return (y == 32'd0) ? 1 : W + 1;
`else
        return W + 1;
`endif
    endfunction

    // Called just after the accept edge; returns in the result_valid cycle with start untouched.
    task automatic wait_result(input logic [63:0] exp, input int elat, input string name);
        int lat = 0;
        bit stall_ok = 1'b1;
        while (result_valid !== 1'b1 && lat < 100) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            a = $urandom;
            b = $urandom;
            is_signed = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (!stall_ok) begin
            errors++;
            $display("FAIL %s stall_busy: stall dropped while busy, required 1 throughout", name);
        end
        checks++;
        if (lat != elat) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required %0d", name, lat, elat);
        end
        checks++;
        if (result !== exp) begin
            errors++;
            $display("FAIL %s result: got %h, required %h", name, result, exp);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL %s stall_done: got %b, required 0", name, stall);
        end
    endtask

    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic s, input string name);
        a = x;
        b = y;
        is_signed = s;
        start = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL %s stall_accept: got %b, required 1", name, stall);
        end
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                          input logic [63:0] exp, input string name);
        issue(x, y, s, name);
        wait_result(exp, exp_lat(y), name);
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_after: valid=%b stall=%b, required 0 0", name, result_valid, stall);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 1'b0;
        cancel = 1'b0;
        is_signed = 1'b0;
        a = '0;
        b = '0;
        #12;
        checks++;
        if (result !== 64'd0 || result_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: result=%h valid=%b stall=%b, required 0 0 0", result, result_valid, stall);
        end
        #3 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_op(32'd7, 32'd2, 1'b0, 64'h00000001_00000003, "divu_7_2");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, "div_m7_2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, "div_min_m1");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h80000000_00000000, "divu_big");
        run_op(32'h1234_5678, 32'd0, 1'b0, 64'h12345678_FFFFFFFF, "divu_zero");
        run_op(32'hFFFF_FFF9, 32'd0, 1'b1, 64'hFFFFFFF9_FFFFFFFF, "div_zero_neg");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, "div_7_m2");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, "divu_max_1");
    endtask

    task automatic test_random();
        logic [31:0] pool [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        logic [31:0] x, y;
        logic s;
        for (int i = 0; i < 24; i++) begin
            x = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 5)] : ($urandom >> $urandom_range(0, 31));
            s = 1'($urandom_range(0, 1));
            run_op(x, y, s, ref_div(x, y, s), $sformatf("rand%0d", i));
        end
    endtask

    task automatic test_cancel();
        logic [63:0] prev;
        bit seen = 1'b0;
        prev = result;
        issue(32'd100, 32'd7, 1'b0, "cancel_op");
        repeat (10) begin
            @(posedge clk); #1;
        end
        cancel = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        cancel = 1'b0;
        checks++;
        if (stall !== 1'b0 || result_valid !== 1'b0 || result !== prev) begin
            errors++;
            $display("FAIL cancel_idle: stall=%b valid=%b result=%h, required 0 0 %h", stall, result_valid, result, prev);
        end
        repeat (40) begin
            if (result_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL cancel_no_result: result_valid rose after cancel, required none");
        end
        // cancel together with start in IDLE accepts nothing
        a = 32'd5;
        b = 32'd1;
        start = 1'b1;
        cancel = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL cancel_start_stall: got %b, required 0", stall);
        end
        @(posedge clk); #1;
        start = 1'b0;
        cancel = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL cancel_start_accept: stall=%b, required 0 (nothing accepted)", stall);
        end
        @(posedge clk); #1;
        run_op(32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, "after_cancel");
    endtask

    task automatic test_reset_mid();
        issue(32'd50, 32'd3, 1'b0, "reset_op");
        repeat (20) begin
            @(posedge clk); #1;
        end
        #2 resetn = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if (result !== 64'd0 || result_valid !== 1'b0 || stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: result=%h valid=%b stall=%b, required 0 0 0", result, result_valid, stall);
        end
        #3 resetn = 1'b1;
        @(posedge clk); #1;
        run_op(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, "after_reset");
    endtask

    task automatic test_back_to_back();
        issue(32'd1000, 32'd7, 1'b0, "b2b_first");
        wait_result(ref_div(32'd1000, 32'd7, 1'b0), W + 1, "b2b_first");
        a = 32'hFFFF_FC18;
        b = 32'd9;
        is_signed = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (result_valid !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: valid=%b stall=%b, required 0 1", result_valid, stall);
        end
        @(posedge clk); #1;
        wait_result(ref_div(32'hFFFF_FC18, 32'd9, 1'b1), W + 1, "b2b_second");
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
